mem_port_arbiter: RTL and testbench

//  Shares the single external memory port between instruction fetch (IF) and the load/store

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between instruction fetch (IF) and the
//   load/store path (MEM). Only one bus transaction is in flight at a time.
//   Each completion returns read data and a one-cycle done pulse to the
//   requester that won the port.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   if_req_i/if_addr_i           IF read request, held until if_done_o
//   if_rdata_o/if_done_o         fetched word and one-cycle completion pulse
//   mem_req_i/we/addr/wdata/sel  load/store request, held until mem_done_o
//   mem_rdata_o/mem_done_o       load data and one-cycle completion pulse
//   bus_req_o/we/addr/wdata/sel  external request, held until bus_ack_i
//   bus_rdata_i/bus_ack_i        external read data and completion
//   stall_if_o/stall_mem_o       combinational stall requests to ctrl
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_MEM_STREAK = 4,
    parameter int STREAK_W       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_done_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_done_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic                stall_if_o,
    output logic                stall_mem_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IF_BUSY,
        S_MEM_BUSY,
        S_RESP
    } state_t;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic                grant_mem;

    // MEM is the older instruction and wins, unless IF has already been
    // passed over MAX_MEM_STREAK times in a row.
    always_comb begin
        grant_mem = mem_req_i & (~if_req_i | (streak < STREAK_MAX));
    end

    assign stall_if_o  = if_req_i  & ~if_done_o;
    assign stall_mem_o = mem_req_i & ~mem_done_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            streak      <= '0;
            if_rdata_o  <= '0;
            if_done_o   <= 1'b0;
            mem_rdata_o <= '0;
            mem_done_o  <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_sel_o   <= '0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_mem) begin
                        state       <= S_MEM_BUSY;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                        bus_sel_o   <= mem_sel_i;
                        if (if_req_i)
                            streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
                        else
                            streak <= '0;
                    end else if (if_req_i) begin
                        state       <= S_IF_BUSY;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                        bus_sel_o   <= '1;
                        streak      <= '0;
                    end
                end
                S_IF_BUSY: begin
                    if (bus_ack_i) begin
                        if_rdata_o <= bus_rdata_i;
                        if_done_o  <= 1'b1;
                        bus_req_o  <= 1'b0;
                        state      <= S_RESP;
                    end
                end
                S_MEM_BUSY: begin
                    if (bus_ack_i) begin
                        if (!bus_we_o)
                            mem_rdata_o <= bus_rdata_i;
                        mem_done_o <= 1'b1;
                        bus_req_o  <= 1'b0;
                        state      <= S_RESP;
                    end
                end
                // Requests are not looked at here, so a request still held
                // during its own done pulse is not granted a second time.
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_done_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        stall_if_o;
    logic        stall_mem_o;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_MEM_STREAK(4),
        .STREAK_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i),
        .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } bus_t;

    typedef struct {
        logic        is_mem;
        logic [31:0] rdata;
    } done_t;

    bus_t  exp_bus_q[$];
    done_t exp_done_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bus_t mk_bus(input logic we, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] s);
        bus_t b;
        b.we = we; b.addr = a; b.wdata = wd; b.sel = s;
        return b;
    endfunction

    function automatic done_t mk_done(input logic m, input logic [31:0] rd);
        done_t d;
        d.is_mem = m; d.rdata = rd;
        return d;
    endfunction

    // ---------------- bus responder ----------------
    logic [31:0] bus_mem [logic [31:0]];
    int          bus_wait = 0;
    logic        spur_ack = 1'b0;
    int          wcnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'hBAD0_BAD0;
            wcnt        = 0;
        end else if (bus_req_o) begin
            if (wcnt == bus_wait) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = bus_mem.exists(bus_addr_o) ? bus_mem[bus_addr_o] : 32'hBAD0_BAD0;
                wcnt        = 0;
            end else begin
                bus_ack_i = 1'b0;
                wcnt++;
            end
        end else begin
            bus_ack_i   = spur_ack;
            bus_rdata_i = 32'hBAD0_BAD0;
            wcnt        = 0;
        end
    end

    // ---------------- monitor ----------------
    logic prev_req = 1'b0;
    bus_t snap;
    int   cur_len  = 0;
    int   last_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
            cur_len  = 0;
        end else begin
            if (if_done_o || mem_done_o) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual if=%0b mem=%0b required none t=%0t",
                             if_done_o, mem_done_o, $time);
                end else begin
                    done_t d;
                    d = exp_done_q.pop_front();
                    chk("done_exclusive", 64'(if_done_o & mem_done_o), 64'd0);
                    chk("done_kind", 64'(mem_done_o), 64'(d.is_mem));
                    chk("done_rdata", 64'(mem_done_o ? mem_rdata_o : if_rdata_o), 64'(d.rdata));
                end
            end
            if (bus_req_o && !prev_req) begin
                if (exp_bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bus_req actual addr=%0h required none t=%0t",
                             bus_addr_o, $time);
                end else begin
                    bus_t b;
                    b = exp_bus_q.pop_front();
                    chk("bus_we",    64'(bus_we_o),    64'(b.we));
                    chk("bus_addr",  64'(bus_addr_o),  64'(b.addr));
                    chk("bus_wdata", 64'(bus_wdata_o), 64'(b.wdata));
                    chk("bus_sel",   64'(bus_sel_o),   64'(b.sel));
                end
                snap.we = bus_we_o; snap.addr = bus_addr_o;
                snap.wdata = bus_wdata_o; snap.sel = bus_sel_o;
                cur_len = 1;
            end else if (bus_req_o) begin
                chk("bus_stable", {27'd0, bus_we_o, bus_addr_o, bus_sel_o},
                                  {27'd0, snap.we, snap.addr, snap.sel});
                chk("bus_wdata_stable", 64'(bus_wdata_o), 64'(snap.wdata));
                cur_len++;
            end else if (prev_req) begin
                last_len = cur_len;
            end
            prev_req = bus_req_o;
        end
    end

    // ---------------- requester tasks ----------------
    task automatic wait_done(input logic is_mem);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (is_mem ? mem_done_o : if_done_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual none required %s done", is_mem ? "mem" : "if");
        end
    endtask

    task automatic do_if(input logic [31:0] a);
        if_req_i  = 1'b1;
        if_addr_i = a;
        wait_done(1'b0);
        if_req_i  = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] s);
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_addr_i  = a;
        mem_wdata_i = wd;
        mem_sel_i   = s;
        wait_done(1'b1);
        mem_req_i   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] if_keep;
        logic [31:0] mem_keep;
        bit          seen;

        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
        mem_wdata_i = '0; mem_sel_i = '0;
        bus_ack_i = 1'b0; bus_rdata_i = '0;

        bus_mem[32'h0000_0100] = 32'h00A0_0093;
        bus_mem[32'h0000_3000] = 32'h1234_5678;
        bus_mem[32'h0000_0200] = 32'h0000_0013;
        bus_mem[32'h0000_4000] = 32'hCAFE_F00D;
        bus_mem[32'h0000_0600] = 32'h0060_0000;
        bus_mem[32'h0000_0700] = 32'h0070_0093;
        for (int k = 0; k < 6; k++)
            bus_mem[32'h0000_5000 + 32'(4 * k)] = 32'h5000_0000 + 32'(k);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_req", 64'(bus_req_o), 64'd0);
        chk("rst_bus_fields", {bus_we_o, bus_addr_o, bus_sel_o}, 64'd0);
        chk("rst_bus_wdata", 64'(bus_wdata_o), 64'd0);
        chk("rst_dones", 64'({if_done_o, mem_done_o}), 64'd0);
        chk("rst_rdata", {if_rdata_o, mem_rdata_o}, 64'd0);
        rst = 1'b0;
        idle_cycles(2);

        // IF only, zero-wait ack: cycle-by-cycle latency and stall
        bus_wait = 0;
        exp_bus_q.push_back(mk_bus(1'b0, 32'h100, 32'h0, 4'hF));
        exp_done_q.push_back(mk_done(1'b0, 32'h00A0_0093));
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h100;
        #1;
        chk("if_c0_stall", 64'(stall_if_o), 64'd1);
        chk("if_c0_bus_req", 64'(bus_req_o), 64'd0);
        @(negedge clk); #1;
        chk("if_c1_bus_req", 64'(bus_req_o), 64'd1);
        chk("if_c1_stall", 64'(stall_if_o), 64'd1);
        chk("if_c1_done", 64'(if_done_o), 64'd0);
        @(negedge clk); #1;
        chk("if_c2_done", 64'(if_done_o), 64'd1);
        chk("if_c2_rdata", 64'(if_rdata_o), 64'h00A0_0093);
        chk("if_c2_stall", 64'(stall_if_o), 64'd0);
        chk("if_c2_bus_req", 64'(bus_req_o), 64'd0);
        if_req_i = 1'b0;
        @(negedge clk); #1;
        chk("if_c3_done", 64'(if_done_o), 64'd0);
        idle_cycles(2);

        // Load with one wait cycle
        bus_wait = 1;
        exp_bus_q.push_back(mk_bus(1'b0, 32'h3000, 32'h1111_1111, 4'hF));
        exp_done_q.push_back(mk_done(1'b1, 32'h1234_5678));
        do_mem(1'b0, 32'h3000, 32'h1111_1111, 4'hF);
        chk("load_len", 64'(last_len), 64'd2);
        idle_cycles(2);

        // Store, three wait cycles: bus held 4 cycles, load data untouched
        bus_wait = 3;
        exp_bus_q.push_back(mk_bus(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011));
        exp_done_q.push_back(mk_done(1'b1, 32'h1234_5678));
        do_mem(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011);
        chk("store_len", 64'(last_len), 64'd4);
        @(negedge clk); #1;
        chk("store_done_single", 64'(mem_done_o), 64'd0);
        chk("store_rdata_kept", 64'(mem_rdata_o), 64'h1234_5678);
        bus_wait = 0;
        idle_cycles(2);

        // Simultaneous requests: MEM first, then IF
        exp_bus_q.push_back(mk_bus(1'b0, 32'h4000, 32'h0, 4'hF));
        exp_bus_q.push_back(mk_bus(1'b0, 32'h200, 32'h0, 4'hF));
        exp_done_q.push_back(mk_done(1'b1, 32'hCAFE_F00D));
        exp_done_q.push_back(mk_done(1'b0, 32'h0000_0013));
        @(negedge clk);
        fork
            do_if(32'h200);
            do_mem(1'b0, 32'h4000, 32'h0, 4'hF);
        join
        idle_cycles(2);

        // IF held while MEM re-requests 6 times: M,M,M,M,I,M,M
        for (int k = 0; k < 4; k++)
            exp_bus_q.push_back(mk_bus(1'b0, 32'h5000 + 32'(4 * k), 32'h0, 4'hF));
        exp_bus_q.push_back(mk_bus(1'b0, 32'h600, 32'h0, 4'hF));
        for (int k = 4; k < 6; k++)
            exp_bus_q.push_back(mk_bus(1'b0, 32'h5000 + 32'(4 * k), 32'h0, 4'hF));
        for (int k = 0; k < 4; k++)
            exp_done_q.push_back(mk_done(1'b1, 32'h5000_0000 + 32'(k)));
        exp_done_q.push_back(mk_done(1'b0, 32'h0060_0000));
        for (int k = 4; k < 6; k++)
            exp_done_q.push_back(mk_done(1'b1, 32'h5000_0000 + 32'(k)));
        @(negedge clk);
        fork
            do_if(32'h600);
            begin
                for (int k = 0; k < 6; k++)
                    do_mem(1'b0, 32'h5000 + 32'(4 * k), 32'h0, 4'hF);
            end
        join
        chk("streak_order_drained", 64'(exp_bus_q.size()), 64'd0);
        idle_cycles(2);

        // Spurious acks in IDLE and RESP
        if_keep  = if_rdata_o;
        mem_keep = mem_rdata_o;
        chk("spur_pre_if_rdata", 64'(if_keep), 64'h0060_0000);
        chk("spur_pre_mem_rdata", 64'(mem_keep), 64'h5000_0005);
        spur_ack = 1'b1;
        idle_cycles(3);
        chk("spur_idle_bus_req", 64'(bus_req_o), 64'd0);
        chk("spur_idle_rdata", {if_rdata_o, mem_rdata_o}, {if_keep, mem_keep});
        exp_bus_q.push_back(mk_bus(1'b0, 32'h700, 32'h0, 4'hF));
        exp_done_q.push_back(mk_done(1'b0, 32'h0070_0093));
        do_if(32'h700);
        idle_cycles(3);
        chk("spur_resp_bus_req", 64'(bus_req_o), 64'd0);
        chk("spur_resp_rdata", {if_rdata_o, mem_rdata_o}, {32'h0070_0093, mem_keep});
        spur_ack = 1'b0;
        idle_cycles(2);

        // Reset in the middle of a MEM transaction, then a stale ack
        bus_wait = 5;
        exp_bus_q.push_back(mk_bus(1'b0, 32'h8000, 32'h0, 4'hF));
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h8000;
        mem_wdata_i = '0; mem_sel_i = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus_req_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rmid_bus_req_seen", 64'(seen), 64'd1);
        rst = 1'b1;
        mem_req_i = 1'b0;
        @(negedge clk); #1;
        chk("rmid_bus_req", 64'(bus_req_o), 64'd0);
        chk("rmid_bus_fields", {bus_we_o, bus_addr_o, bus_sel_o}, 64'd0);
        chk("rmid_rdata", {if_rdata_o, mem_rdata_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        spur_ack = 1'b1;
        @(negedge clk); #1;
        spur_ack = 1'b0;
        idle_cycles(4);
        chk("rmid_no_done_rdata", 64'(mem_rdata_o), 64'd0);
        chk("rmid_idle_bus_req", 64'(bus_req_o), 64'd0);
        bus_wait = 0;

        chk("bus_q_empty", 64'(exp_bus_q.size()), 64'd0);
        chk("done_q_empty", 64'(exp_done_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
